// File: rtl/iomem_slot_ctrl_if.sv
// Bus bundle for iomem_slot_ctrl: PicoSoC iomem side plus the shared per-slot request bus.
interface iomem_slot_ctrl_if #(
  parameter int NSLOTS = 4
);
  logic                     iomem_valid;
  logic                     iomem_ready;
  logic [3:0]               iomem_wstrb;
  logic [31:0]              iomem_addr;
  logic [31:0]              iomem_wdata;
  logic [31:0]              iomem_rdata;
  logic [NSLOTS-1:0]        s_valid;
  logic [NSLOTS-1:0]        s_ready;
  logic [3:0]               s_wstrb;
  logic [19:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [32*NSLOTS-1:0]     s_rdata;

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
    output iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
    input  iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );
endinterface

// File: rtl/iomem_slot_ctrl.sv
// Claims one iomem region, sequences a request/ack handshake to one of NSLOTS slots,
// and answers unmapped or hung slots with ERR_DATA so the CPU never stalls.
module iomem_slot_ctrl #(
  parameter int          NSLOTS   = 4,
  parameter logic [7:0]  REGION   = 8'h03,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hBADC0DE0
) (
  input  logic                clk,
  input  logic                resetn,
  iomem_slot_ctrl_if.slave    bus,
  output logic                err_irq,
  output logic [7:0]          err_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [4:0]  NS5 = 5'(NSLOTS);
  localparam logic [15:0] TO16 = 16'(TIMEOUT);

  state_t      state;
  logic [3:0]  slot;
  logic [15:0] cnt;
  logic [3:0]  req_slot;
  logic        claim;
  logic        ack;
  logic [31:0] rd_sel;

  assign req_slot = bus.iomem_addr[23:20];
  assign claim    = bus.iomem_valid && (bus.iomem_addr[31:24] == REGION) &&
                    (state == IDLE) && !bus.iomem_ready;
  // s_valid is one-hot on the latched slot, so this masks off every other slot's ack
  assign ack      = |(bus.s_ready & bus.s_valid);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NSLOTS; i++)
      if (slot == 4'(i)) rd_sel = bus.s_rdata[i*32 +: 32];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      slot            <= '0;
      cnt             <= '0;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      bus.s_valid     <= '0;
      bus.s_wstrb     <= '0;
      bus.s_addr      <= '0;
      bus.s_wdata     <= '0;
      err_irq         <= 1'b0;
      err_count       <= '0;
    end else begin
      bus.iomem_ready <= 1'b0;
      err_irq         <= 1'b0;
      case (state)
        IDLE: begin
          bus.iomem_rdata <= '0;
          if (claim) begin
            if ({1'b0, req_slot} < NS5) begin
              state       <= ACCESS;
              slot        <= req_slot;
              cnt         <= '0;
              bus.s_valid <= NSLOTS'(1) << req_slot;
              bus.s_addr  <= bus.iomem_addr[19:0];
              bus.s_wstrb <= bus.iomem_wstrb;
              bus.s_wdata <= bus.iomem_wdata;
            end else begin
              // unmapped slot: error straight away, nothing reaches the slots
              state           <= RESP;
              bus.iomem_ready <= 1'b1;
              bus.iomem_rdata <= ERR_DATA;
              err_irq         <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 16'd1;
          if (ack) begin
            state           <= RESP;
            bus.s_valid     <= '0;
            bus.iomem_ready <= 1'b1;
            bus.iomem_rdata <= (bus.s_wstrb != 4'd0) ? 32'd0 : rd_sel;
          end else if (cnt == TO16) begin
            state           <= RESP;
            bus.s_valid     <= '0;
            bus.iomem_ready <= 1'b1;
            bus.iomem_rdata <= ERR_DATA;
            err_irq         <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        RESP: begin
          state           <= IDLE;
          bus.iomem_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_slot_ctrl.sv
// Vector table plus randomized transfers for iomem_slot_ctrl, checked against a transfer-level model.
module tb_iomem_slot_ctrl;
  localparam int          NS  = 4;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hBADC0DE0;

  logic       clk;
  logic       resetn;
  logic       err_irq;
  logic [7:0] err_count;

  iomem_slot_ctrl_if #(.NSLOTS(NS)) bus ();

  iomem_slot_ctrl #(.NSLOTS(NS), .REGION(8'h03), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .err_irq(err_irq), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  logic [31:0] slot_data [NS];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  ws;
    logic [31:0] wd;
    int          dly;
    int          e_lat;
    int          e_svc;
    logic [31:0] e_rd;
    logic        e_err;
    logic [3:0]  e_mask;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic load_rdata();
    for (int i = 0; i < NS; i++) bus.s_rdata[i*32 +: 32] = slot_data[i];
  endtask

  // Expected outcome of one claimed transfer, from the protocol rules only
  task automatic model(input logic [31:0] addr, input logic [3:0] ws, input int dly,
                       output int lat, output int svc, output logic [31:0] rd,
                       output logic err, output logic [3:0] mask);
    int s;
    s = int'(addr[23:20]);
    if (s >= NS) begin
      lat = 1; svc = 0; rd = ERR; err = 1'b1; mask = '0;
    end else begin
      mask = 4'(1) << s;
      if (dly <= TO) begin
        lat = dly + 2; svc = dly + 1; err = 1'b0;
        rd  = (ws == 4'd0) ? slot_data[s] : 32'd0;
      end else begin
        lat = TO + 2; svc = TO + 1; rd = ERR; err = 1'b1;
      end
    end
  endtask

  // Slot side acks dly cycles after s_valid rises; noise toggles other slots' s_ready
  task automatic xfer(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                      input int dly, input bit noise,
                      output int lat, output int svc, output logic [31:0] rd,
                      output logic irq, output logic stable, output logic [3:0] seen);
    logic [3:0] sel;
    sel = (int'(addr[23:20]) < NS) ? (4'(1) << addr[23:20]) : 4'd0;
    @(negedge clk);
    bus.iomem_valid = 1'b1; bus.iomem_addr = addr;
    bus.iomem_wstrb = ws;   bus.iomem_wdata = wd;
    bus.s_ready = '0;
    lat = 0; svc = 0; rd = '0; irq = 1'b0; stable = 1'b1; seen = '0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (|bus.s_valid) begin
        svc++;
        seen |= bus.s_valid;
        if (bus.s_addr !== addr[19:0] || bus.s_wstrb !== ws || bus.s_wdata !== wd) stable = 1'b0;
      end
      if (bus.iomem_ready) begin
        rd = bus.iomem_rdata; irq = err_irq;
        break;
      end
      bus.s_ready = noise ? (4'($urandom) & ~sel) : 4'd0;
      if ((|bus.s_valid) && (svc - 1 >= dly)) bus.s_ready = bus.s_ready | sel;
    end
    bus.iomem_valid = 1'b0;
    bus.s_ready = '0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] addr, input logic [3:0] ws,
                           input logic [31:0] wd, input int dly, input bit noise,
                           input int e_lat, input int e_svc, input logic [31:0] e_rd,
                           input logic e_err, input logic [3:0] e_mask);
    int lat, svc;
    logic [31:0] rd;
    logic irq, stable;
    logic [3:0] seen;
    xfer(addr, ws, wd, dly, noise, lat, svc, rd, irq, stable, seen);
    if (e_err && exp_cnt < 255) exp_cnt++;
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " s_valid cycles"}, 32'(svc), 32'(e_svc));
    chk({tag, " s_valid slot"}, 32'(seen), 32'(e_mask));
    chk({tag, " rdata"}, rd, e_rd);
    chk({tag, " err_irq"}, 32'(irq), 32'(e_err));
    chk({tag, " slot bus stable"}, 32'(stable), 32'd1);
    chk({tag, " err_count"}, 32'(err_count), 32'(exp_cnt));
  endtask

  initial begin
    vec_t vt [6];
    int lat, svc;
    logic [31:0] rd;
    logic err;
    logic [3:0] mask;
    logic [31:0] a, wd;
    logic [3:0] ws;
    int dly, dsel;
    logic hit;

    resetn = 1'b0;
    bus.iomem_valid = 1'b0; bus.iomem_addr = '0; bus.iomem_wstrb = '0; bus.iomem_wdata = '0;
    bus.s_ready = '0;
    slot_data[0] = 32'h12345678; slot_data[1] = 32'h11111111;
    slot_data[2] = 32'h22222222; slot_data[3] = 32'h33333333;
    load_rdata();

    vt[0] = '{32'h03000004, 4'h0, 32'h0,        0,    2,      1,      32'h12345678, 1'b0, 4'b0001};
    vt[1] = '{32'h03200010, 4'hF, 32'hA5A5A5A5, 3,    5,      4,      32'h0,        1'b0, 4'b0100};
    vt[2] = '{32'h03500000, 4'h0, 32'h0,        0,    1,      0,      ERR,          1'b1, 4'b0000};
    vt[3] = '{32'h03100000, 4'h0, 32'h0,        1000, TO + 2, TO + 1, ERR,          1'b1, 4'b0010};
    vt[4] = '{32'h03300008, 4'h0, 32'h0,        TO,   TO + 2, TO + 1, 32'h33333333, 1'b0, 4'b1000};
    vt[5] = '{32'h03F00000, 4'h3, 32'hDEADBEEF, 0,    1,      0,      ERR,          1'b1, 4'b0000};

    #3;
    chk("reset iomem_ready", 32'(bus.iomem_ready), 32'd0);
    chk("reset iomem_rdata", bus.iomem_rdata, 32'd0);
    chk("reset s_valid", 32'(bus.s_valid), 32'd0);
    chk("reset s_wstrb", 32'(bus.s_wstrb), 32'd0);
    chk("reset s_addr", 32'(bus.s_addr), 32'd0);
    chk("reset s_wdata", bus.s_wdata, 32'd0);
    chk("reset err_irq", 32'(err_irq), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), vt[i].addr, vt[i].ws, vt[i].wd, vt[i].dly, 1'b0,
                vt[i].e_lat, vt[i].e_svc, vt[i].e_rd, vt[i].e_err, vt[i].e_mask);

    // timeout on slot 1, then a late ack that must be ignored
    run_check("timeout", 32'h03100040, 4'h0, 32'h0, 1000, 1'b0, TO + 2, TO + 1, ERR, 1'b1, 4'b0010);
    bus.s_ready = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("late ack iomem_ready", 32'(bus.iomem_ready), 32'd0);
      chk("late ack s_valid", 32'(bus.s_valid), 32'd0);
    end
    bus.s_ready = '0;
    chk("late ack err_count", 32'(err_count), 32'(exp_cnt));

    // foreign region: no response at all
    @(negedge clk);
    bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h02000000; bus.iomem_wstrb = 4'h0;
    hit = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.iomem_ready || (|bus.s_valid)) hit = 1'b1;
    end
    bus.iomem_valid = 1'b0;
    chk("foreign region response", 32'(hit), 32'd0);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
      load_rdata();
      a    = {8'h03, 4'($urandom_range(0, 5)), 20'($urandom)};
      ws   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      wd   = $urandom;
      dsel = $urandom_range(0, 6);
      dly  = (dsel < 4) ? dsel : (dsel == 4) ? TO : (dsel == 5) ? TO + 1 : 1000;
      model(a, ws, dly, lat, svc, rd, err, mask);
      run_check($sformatf("rand%0d", t), a, ws, wd, dly, 1'b1, lat, svc, rd, err, mask);
    end

    // asynchronous reset in the middle of an ACCESS
    @(negedge clk);
    bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h03100000; bus.iomem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("pre-reset s_valid", 32'(bus.s_valid), 32'b0010);
    #2 resetn = 1'b0;
    #1;
    chk("async reset s_valid", 32'(bus.s_valid), 32'd0);
    chk("async reset iomem_ready", 32'(bus.iomem_ready), 32'd0);
    chk("async reset err_count", 32'(err_count), 32'd0);
    bus.iomem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_cnt = 0;

    for (int t = 0; t < 300; t++)
      run_check($sformatf("sat%0d", t), {8'h03, 4'($urandom_range(4, 15)), 20'($urandom)},
                4'h0, 32'h0, 0, 1'b0, 1, 0, ERR, 1'b1, 4'b0000);
    chk("err_count saturated", 32'(err_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
